// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Shared types for the AXI4-Lite peripheral blocks.
//   resp_t          : AXI response codes used on bresp/rresp
//   regbank_state_t : transaction state of the register-bank slave
//   prio_t          : which side wins the next read/write contention
//   BYTE_W          : width of one byte lane selected by a strobe bit
// No ports (package only).
// ---------------------------------------------------------------------------
package axi_lite_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_RESP,
    WR_RESP
  } regbank_state_t;

  typedef enum logic {
    PRIO_READ,
    PRIO_WRITE
  } prio_t;

endpackage

// File: rtl/axi_lite_regbank_mem.sv
// ---------------------------------------------------------------------------
// axi_lite_regbank_mem
// DEPTH x DATA_W register storage with a byte-enable write port and a
// combinational read port. A synchronous reset loads every word with
// RESET_VAL.
// Ports:
//   aclk     in   clock
//   areset   in   synchronous active-high reset
//   wr_en    in   commit wr_data into word wr_idx this edge
//   wr_idx   in   word index of the write
//   wr_data  in   write data
//   wr_strb  in   one bit per byte lane; only set lanes are written
//   rd_idx   in   word index of the read
//   rd_data  out  contents of word rd_idx (combinational)
// ---------------------------------------------------------------------------
module axi_lite_regbank_mem
  import axi_lite_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_idx,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/8-1:0]        wr_strb,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [DATA_W-1:0]          rd_data
);

  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) begin
          mem_q[wr_idx][b*BYTE_W +: BYTE_W] <= wr_data[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/axi_lite_regbank_slave.sv
// ---------------------------------------------------------------------------
// axi_lite_regbank_slave
// AXI4-Lite slave backed by a DEPTH x DATA_W register bank. AW and W are
// captured independently (either order), reads and writes share one
// response slot and alternate fairly when both are pending. Addresses
// beyond the bank answer SLVERR (reads return 0, writes are dropped).
// Ports:
//   aclk, areset                       clock, synchronous active-high reset
//   awaddr, awvalid, awready           write address channel
//   wdata, wstrb, wvalid, wready       write data channel
//   bresp, bvalid, bready              write response channel
//   araddr, arvalid, arready           read address channel
//   rdata, rresp, rvalid, rready       read data channel
// ---------------------------------------------------------------------------
module axi_lite_regbank_slave
  import axi_lite_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int IDX_LSB = $clog2(STRB_W);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_SPAN = ADDR_W'(DEPTH * STRB_W);

  regbank_state_t      state;
  regbank_state_t      state_next;
  prio_t               prio;
  logic                aw_held;
  logic                w_held;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [STRB_W-1:0]   w_strb_q;
  logic [DATA_W-1:0]   rdata_q;
  resp_t               rresp_q;
  resp_t               bresp_q;
  logic [DATA_W-1:0]   mem_rd_data;
  logic                aw_hs;
  logic                w_hs;
  logic                ar_hs;
  logic                wr_cand;
  logic                wr_grant;
  logic                ar_in_range;
  logic                aw_in_range;

  assign ar_in_range = (araddr < ADDR_SPAN);
  assign aw_in_range = (aw_addr_q < ADDR_SPAN);
  assign wr_cand     = aw_held && w_held;

  // Every handshake output is forced low during reset so nothing is accepted
  // or presented before the state has actually been cleared.
  assign awready = !areset && !aw_held && (state != WR_RESP);
  assign wready  = !areset && !w_held  && (state != WR_RESP);
  // arready depends only on state/prio/held flags, never on arvalid; a
  // write with priority blocks the read so the write wins the slot.
  assign arready = !areset && (state == IDLE) && !(wr_cand && (prio == PRIO_WRITE));

  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign ar_hs    = arvalid && arready;
  assign wr_grant = !areset && (state == IDLE) && wr_cand && !ar_hs;

  assign rvalid = !areset && (state == RD_RESP);
  assign bvalid = !areset && (state == WR_RESP);
  assign rdata  = areset ? '0 : rdata_q;
  assign rresp  = areset ? RESP_OKAY : rresp_q;
  assign bresp  = areset ? RESP_OKAY : bresp_q;

  // FSM state register
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: one outstanding transaction, released by the matching ready
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ar_hs) begin
          state_next = RD_RESP;
        end else if (wr_grant) begin
          state_next = WR_RESP;
        end
      end
      RD_RESP: begin
        if (rready) begin
          state_next = IDLE;
        end
      end
      WR_RESP: begin
        if (bready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // AW/W capture; a granted write empties both holding slots
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (wr_grant) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
    end
  end

  // Whichever side wins hands priority to the other side
  always_ff @(posedge aclk) begin
    if (areset) begin
      prio <= PRIO_READ;
    end else if (ar_hs) begin
      prio <= PRIO_WRITE;
    end else if (wr_grant) begin
      prio <= PRIO_READ;
    end
  end

  // Response registers are loaded once at grant and held until the ready
  always_ff @(posedge aclk) begin
    if (areset) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      bresp_q <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        rdata_q <= ar_in_range ? mem_rd_data : '0;
        rresp_q <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      if (wr_grant) begin
        bresp_q <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  axi_lite_regbank_mem #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .RESET_VAL (RESET_VAL)
  ) u_mem (
    .aclk    (aclk),
    .areset  (areset),
    .wr_en   (wr_grant && aw_in_range),
    .wr_idx  (aw_addr_q[IDX_LSB +: IDX_W]),
    .wr_data (w_data_q),
    .wr_strb (w_strb_q),
    .rd_idx  (araddr[IDX_LSB +: IDX_W]),
    .rd_data (mem_rd_data)
  );

endmodule

// File: tb/tb_axi_lite_regbank_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_regbank_slave
// Scoreboard bench for axi_lite_regbank_slave (32-bit data, 32 words).
// Expected responses are queued when a transaction is issued and popped by
// a monitor when the slave presents rvalid/bvalid.
// ---------------------------------------------------------------------------
module tb_axi_lite_regbank_slave;
  import axi_lite_pkg::*;

  localparam int          ADDR_W  = 32;
  localparam int          DATA_W  = 32;
  localparam int          DEPTH   = 32;
  localparam logic [31:0] RST_VAL = 32'h5A5A_1234;
  localparam logic [31:0] SPAN    = 32'h80;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  rd_exp_t     rdQ[$];
  logic [1:0]  bQ[$];
  logic [31:0] model [DEPTH];
  bit          logEn = 1'b0;
  byte         grantLog[$];
  rd_exp_t     monRd;
  logic [1:0]  monB;

  int testsRun    = 0;
  int testsFailed = 0;

  axi_lite_regbank_slave #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .RESET_VAL (RST_VAL)
  ) dut (
    .aclk    (aclk),
    .areset  (areset),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  always #5 aclk = ~aclk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic rd_exp_t readExp(input logic [31:0] addr);
    rd_exp_t e;
    if (addr >= SPAN) begin
      e.data = 32'h0;
      e.resp = RESP_SLVERR;
    end else begin
      e.data = model[addr[6:2]];
      e.resp = RESP_OKAY;
    end
    return e;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < DEPTH; i++) model[i] = RST_VAL;
  endtask

  // Monitor: pops the scoreboard whenever a response is being accepted
  always @(negedge aclk) begin
    if (!areset) begin
      if (rvalid && rready) begin
        if (logEn) grantLog.push_back(8'h52);
        if (rdQ.size() == 0) begin
          checkOutput("spurious_rvalid", 64'(rvalid), 64'd0);
        end else begin
          monRd = rdQ.pop_front();
          checkOutput("rdata", 64'(rdata), 64'(monRd.data));
          checkOutput("rresp", 64'(rresp), 64'(monRd.resp));
        end
      end
      if (bvalid && bready) begin
        if (logEn) grantLog.push_back(8'h57);
        if (bQ.size() == 0) begin
          checkOutput("spurious_bvalid", 64'(bvalid), 64'd0);
        end else begin
          monB = bQ.pop_front();
          checkOutput("bresp", 64'(bresp), 64'(monB));
        end
      end
    end
  end

  // Issues one read (isWrite=0) or one write. For writes, wLead >= 0 starts
  // W wLead cycles before AW; a negative wLead starts AW first.
  task automatic applyStimulus(input bit isWrite, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               input int wLead);
    bit done;
    bit hs;
    bit awDone;
    bit wDone;
    bit awHs;
    bit wHs;
    int awStart;
    int wStart;
    if (!isWrite) begin
      rdQ.push_back(readExp(addr));
      araddr  = addr;
      arvalid = 1'b1;
      done    = 1'b0;
      for (int c = 0; c < 50 && !done; c++) begin
        @(negedge aclk);
        hs = arready;
        @(posedge aclk);
        #1;
        if (hs) done = 1'b1;
      end
      arvalid = 1'b0;
      if (!done) begin
        checkOutput("ar_timeout", 64'(done), 64'd1);
      end else begin
        @(negedge aclk);
        checkOutput("rvalid_latency", 64'(rvalid), 64'd1);
      end
    end else begin
      if (addr >= SPAN) begin
        bQ.push_back(RESP_SLVERR);
      end else begin
        bQ.push_back(RESP_OKAY);
        for (int b = 0; b < 4; b++)
          if (strb[b]) model[addr[6:2]][b*8 +: 8] = data[b*8 +: 8];
      end
      awStart = (wLead >= 0) ? wLead : 0;
      wStart  = (wLead >= 0) ? 0 : -wLead;
      awDone  = 1'b0;
      wDone   = 1'b0;
      for (int c = 0; c < 60 && !(awDone && wDone); c++) begin
        if (!wDone && c >= wStart) begin
          wvalid = 1'b1;
          wdata  = data;
          wstrb  = strb;
        end
        if (!awDone && c >= awStart) begin
          awvalid = 1'b1;
          awaddr  = addr;
        end
        @(negedge aclk);
        awHs = awvalid && awready;
        wHs  = wvalid && wready;
        @(posedge aclk);
        #1;
        if (awHs) begin awDone = 1'b1; awvalid = 1'b0; end
        if (wHs)  begin wDone  = 1'b1; wvalid  = 1'b0; end
      end
      awvalid = 1'b0;
      wvalid  = 1'b0;
      if (!(awDone && wDone)) begin
        checkOutput("aw_w_timeout", 64'(awDone && wDone), 64'd1);
      end else begin
        @(negedge aclk);
        checkOutput("bvalid_commit_cycle", 64'(bvalid), 64'd0);
        @(negedge aclk);
        checkOutput("bvalid_latency", 64'(bvalid), 64'd1);
      end
    end
  endtask

  // Waits (bounded) until every queued response has been seen
  task automatic waitIdle();
    int n;
    n = 0;
    while ((rdQ.size() != 0 || bQ.size() != 0) && n < 50) begin
      @(posedge aclk);
      #1;
      n++;
    end
    if (rdQ.size() != 0 || bQ.size() != 0) begin
      checkOutput("response_timeout", 64'(rdQ.size() + bQ.size()), 64'd0);
      rdQ.delete();
      bQ.delete();
    end
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int arCnt;
    int awCnt;
    int wCnt;
    bit arHs;
    bit awHs;
    bit wHs;

    areset  = 1'b1;
    awaddr  = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wvalid  = 1'b0;
    bready  = 1'b1;
    araddr  = '0;
    arvalid = 1'b0;
    rready  = 1'b1;
    resetModel();

    // Reset: all handshake outputs low, response fields idle
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checkOutput("rst_awready", 64'(awready), 64'd0);
    checkOutput("rst_wready",  64'(wready),  64'd0);
    checkOutput("rst_arready", 64'(arready), 64'd0);
    checkOutput("rst_rvalid",  64'(rvalid),  64'd0);
    checkOutput("rst_bvalid",  64'(bvalid),  64'd0);
    checkOutput("rst_rdata",   64'(rdata),   64'd0);
    checkOutput("rst_rresp",   64'(rresp),   64'(RESP_OKAY));
    checkOutput("rst_bresp",   64'(bresp),   64'(RESP_OKAY));
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    checkOutput("idle_arready", 64'(arready), 64'd1);
    checkOutput("idle_awready", 64'(awready), 64'd1);
    @(posedge aclk);
    #1;

    // 1: reset contents at the first and last word
    applyStimulus(1'b0, 32'h00, 32'h0, 4'h0, 0);
    waitIdle();
    applyStimulus(1'b0, 32'h7C, 32'h0, 4'h0, 0);
    waitIdle();

    // 2: W two cycles ahead of AW
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2);
    waitIdle();
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 0);
    waitIdle();

    // 3: full write, partial strobe merge (AW first), then empty strobe
    applyStimulus(1'b1, 32'h08, 32'h11223344, 4'hF, 0);
    waitIdle();
    applyStimulus(1'b1, 32'h08, 32'hAABBCCDD, 4'b0101, -1);
    waitIdle();
    applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, 0);
    waitIdle();
    applyStimulus(1'b1, 32'h08, 32'hFFFFFFFF, 4'h0, 1);
    waitIdle();
    applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, 0);
    waitIdle();

    // 4: out-of-range write and read; aliasing word 0 must be untouched
    applyStimulus(1'b1, 32'h80, 32'h12345678, 4'hF, 0);
    waitIdle();
    applyStimulus(1'b0, 32'h84, 32'h0, 4'h0, 0);
    waitIdle();
    applyStimulus(1'b0, 32'h00, 32'h0, 4'h0, 0);
    waitIdle();

    // 5: read and write requests always pending -> grants alternate R,W,...
    for (int i = 0; i < 4; i++) begin
      rdQ.push_back(readExp(32'h20));
      bQ.push_back(RESP_OKAY);
    end
    model[32'h30 >> 2] = 32'hCAFEF00D;
    grantLog.delete();
    logEn   = 1'b1;
    araddr  = 32'h20;
    arvalid = 1'b1;
    awaddr  = 32'h30;
    awvalid = 1'b1;
    wdata   = 32'hCAFEF00D;
    wstrb   = 4'hF;
    wvalid  = 1'b1;
    arCnt = 0;
    awCnt = 0;
    wCnt  = 0;
    for (int c = 0; c < 100 && (arCnt < 4 || awCnt < 4 || wCnt < 4); c++) begin
      @(negedge aclk);
      arHs = arvalid && arready;
      awHs = awvalid && awready;
      wHs  = wvalid && wready;
      @(posedge aclk);
      #1;
      if (arHs) arCnt++;
      if (awHs) awCnt++;
      if (wHs)  wCnt++;
      if (arCnt == 4) arvalid = 1'b0;
      if (awCnt == 4) awvalid = 1'b0;
      if (wCnt == 4)  wvalid  = 1'b0;
    end
    arvalid = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    waitIdle();
    logEn = 1'b0;
    checkOutput("grant_count", 64'(grantLog.size()), 64'd8);
    for (int i = 0; i < grantLog.size(); i++)
      checkOutput($sformatf("grant_order_%0d", i), 64'(grantLog[i]),
                  (i % 2 == 0) ? 64'h52 : 64'h57);
    applyStimulus(1'b0, 32'h30, 32'h0, 4'h0, 0);
    waitIdle();

    // 6: stalled read response stays stable; reset abandons it
    rready = 1'b0;
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      checkOutput("stall_rvalid", 64'(rvalid), 64'd1);
      checkOutput("stall_rdata",  64'(rdata),  64'h0000_0000_DEAD_BEEF);
      checkOutput("stall_rresp",  64'(rresp),  64'(RESP_OKAY));
    end
    @(posedge aclk);
    #1;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    @(negedge aclk);
    checkOutput("midrst_rvalid",  64'(rvalid),  64'd0);
    checkOutput("midrst_rdata",   64'(rdata),   64'd0);
    checkOutput("midrst_arready", 64'(arready), 64'd0);
    rdQ.delete();
    bQ.delete();
    resetModel();
    @(posedge aclk);
    #1;
    areset = 1'b0;
    rready = 1'b1;
    @(posedge aclk);
    #1;
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 0);
    waitIdle();
    applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, 0);
    waitIdle();
    applyStimulus(1'b0, 32'h30, 32'h0, 4'h0, 0);
    waitIdle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
